// File: rtl/pkg_pipeline.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   SEL_*   : encodings for the EX-stage operand forwarding muxes
//   slot_t  : scoreboard descriptor of one in-flight instruction
//   acao_t  : per-cycle action taken by the controller
package pkg_pipeline;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    typedef struct packed {
        logic             valido;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dest;
    } slot_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } acao_t;

    // Slot produces register r; register 0 never counts as a dependency.
    function automatic logic casa(slot_t s, logic [REG_W-1:0] r);
        return s.valido & s.regwrite & (s.dest == r) & (r != '0);
    endfunction

endpackage

// File: rtl/unidade_adiantamento.sv
// Forwarding comparator for one EX-stage operand.
//   operando          : register specifier read by the instruction in ID
//   ex_* / mem_*      : scoreboard fields of the EX and MEM slots
//   sel_c             : 2-bit mux select (combinational), nearest producer wins
module unidade_adiantamento
    import pkg_pipeline::*;
(
    input  logic [REG_W-1:0] operando,
    input  logic             ex_valido,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_valido,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_dest,
    output logic [1:0]       sel_c
);

    logic nao_zero;
    logic casa_ex;
    logic casa_mem;

    always_comb begin
        nao_zero = (operando != '0);
        casa_ex  = ex_valido  & ex_regwrite  & (ex_dest  == operando) & nao_zero;
        casa_mem = mem_valido & mem_regwrite & (mem_dest == operando) & nao_zero;
        sel_c    = SEL_REG;
        // A load in EX has no result yet; a load-use stall covers that case.
        if (casa_ex && !ex_memread) begin
            sel_c = SEL_MEM;
        end else if (casa_mem) begin
            sel_c = SEL_WB;
        end
    end

endmodule

// File: rtl/controle_hazard.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   id_*                : descriptor of the instruction currently in ID
//   desvio_tomado       : taken branch/jump resolved in EX
//   mem_pronta          : data memory ready (0 freezes the pipeline)
//   pc_escreve, ifid_escreve, ifid_limpa, idex_bolha : pipeline control (combinational)
//   controle1P/2P, controle1S/2S : registered rs/rt forwarding selects
//   contador_bolhas     : saturating count of inserted bubbles
module controle_hazard
    import pkg_pipeline::*;
#(
    parameter int unsigned REG_BITS     = 5,
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [REG_BITS-1:0]     id_rs,
    input  logic [REG_BITS-1:0]     id_rt,
    input  logic [REG_BITS-1:0]     id_rd,
    input  logic                    id_usa_rs,
    input  logic                    id_usa_rt,
    input  logic                    id_regDest,
    input  logic                    id_regwrite,
    input  logic                    id_memread,
    input  logic                    desvio_tomado,
    input  logic                    mem_pronta,
    output logic                    pc_escreve,
    output logic                    ifid_escreve,
    output logic                    ifid_limpa,
    output logic                    idex_bolha,
    output logic                    controle1P,
    output logic                    controle2P,
    output logic                    controle1S,
    output logic                    controle2S,
    output logic [LARGURA_CONT-1:0] contador_bolhas
);

    slot_t                   ex_q;
    slot_t                   mem_q;
    slot_t                   wb_q;
    slot_t                   id_desc;
    acao_t                   acao;
    logic                    carga_uso;
    logic [REG_W-1:0]        rs_w;
    logic [REG_W-1:0]        rt_w;
    logic [1:0]              sel_rs_c;
    logic [1:0]              sel_rt_c;
    logic [1:0]              sel_rs_q;
    logic [1:0]              sel_rt_q;
    logic [LARGURA_CONT-1:0] cont_q;

    // WB slot only tracks retirement; MEM.memread is never consulted.
    logic sobra_unused;
    assign sobra_unused = ^{wb_q, mem_q.memread};

    // Descriptor the ID instruction carries into EX.
    always_comb begin
        rs_w             = REG_W'(id_rs);
        rt_w             = REG_W'(id_rt);
        id_desc.valido   = 1'b1;
        id_desc.regwrite = id_regwrite;
        id_desc.memread  = id_memread;
        id_desc.dest     = id_regDest ? REG_W'(id_rd) : REG_W'(id_rt);
    end

    // Action selection, highest priority first.
    always_comb begin
        carga_uso = ex_q.memread & ((id_usa_rs & casa(ex_q, rs_w)) |
                                    (id_usa_rt & casa(ex_q, rt_w)));
        acao = NORMAL;
        if (!mem_pronta) begin
            acao = FREEZE;
        end else if (desvio_tomado) begin
            acao = FLUSH;
        end else if (carga_uso) begin
            acao = STALL;
        end
    end

    // Pipeline control lines; all low while reset is held.
    always_comb begin
        pc_escreve   = 1'b0;
        ifid_escreve = 1'b0;
        ifid_limpa   = 1'b0;
        idex_bolha   = 1'b0;
        if (!reset) begin
            unique case (acao)
                NORMAL: begin
                    pc_escreve   = 1'b1;
                    ifid_escreve = 1'b1;
                end
                FLUSH: begin
                    pc_escreve   = 1'b1;
                    ifid_escreve = 1'b1;
                    ifid_limpa   = 1'b1;
                    idex_bolha   = 1'b1;
                end
                STALL: begin
                    idex_bolha   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    unidade_adiantamento u_adiant_rs (
        .operando     (rs_w),
        .ex_valido    (ex_q.valido),
        .ex_regwrite  (ex_q.regwrite),
        .ex_memread   (ex_q.memread),
        .ex_dest      (ex_q.dest),
        .mem_valido   (mem_q.valido),
        .mem_regwrite (mem_q.regwrite),
        .mem_dest     (mem_q.dest),
        .sel_c        (sel_rs_c)
    );

    unidade_adiantamento u_adiant_rt (
        .operando     (rt_w),
        .ex_valido    (ex_q.valido),
        .ex_regwrite  (ex_q.regwrite),
        .ex_memread   (ex_q.memread),
        .ex_dest      (ex_q.dest),
        .mem_valido   (mem_q.valido),
        .mem_regwrite (mem_q.regwrite),
        .mem_dest     (mem_q.dest),
        .sel_c        (sel_rt_c)
    );

    // Scoreboard shift, forwarding select registers and bubble counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            sel_rs_q <= SEL_REG;
            sel_rt_q <= SEL_REG;
            cont_q   <= '0;
        end else begin
            unique case (acao)
                NORMAL: begin
                    wb_q     <= mem_q;
                    mem_q    <= ex_q;
                    ex_q     <= id_desc;
                    sel_rs_q <= sel_rs_c;
                    sel_rt_q <= sel_rt_c;
                end
                FLUSH, STALL: begin
                    wb_q     <= mem_q;
                    mem_q    <= ex_q;
                    ex_q     <= '0;
                    sel_rs_q <= SEL_REG;
                    sel_rt_q <= SEL_REG;
                    if (cont_q != '1) begin
                        cont_q <= cont_q + LARGURA_CONT'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign controle1P      = sel_rs_q[1];
    assign controle2P      = sel_rs_q[0];
    assign controle1S      = sel_rt_q[1];
    assign controle2S      = sel_rt_q[0];
    assign contador_bolhas = cont_q;

endmodule

// File: tb/tb_controle_hazard.sv
module tb_controle_hazard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_usa_rs, id_usa_rt, id_regDest, id_regwrite, id_memread;
    logic        desvio_tomado, mem_pronta;
    logic        pc_escreve, ifid_escreve, ifid_limpa, idex_bolha;
    logic        controle1P, controle2P, controle1S, controle2S;
    logic [15:0] contador_bolhas;

    int total = 0;
    int bad   = 0;

    controle_hazard dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt),
        .id_regDest(id_regDest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .desvio_tomado(desvio_tomado), .mem_pronta(mem_pronta),
        .pc_escreve(pc_escreve), .ifid_escreve(ifid_escreve),
        .ifid_limpa(ifid_limpa), .idex_bolha(idex_bolha),
        .controle1P(controle1P), .controle2P(controle2P),
        .controle1S(controle1S), .controle2S(controle2S),
        .contador_bolhas(contador_bolhas)
    );

    always #5 clock = ~clock;

    // Reference model: history of what entered EX, most recent first.
    typedef struct { bit v; bit rw; bit mr; logic [4:0] d; } ent_t;
    ent_t hist[$];
    logic [1:0] m_selP, m_selS;
    int         m_cnt;
    bit         model_ok = 0;

    function automatic bit produz(ent_t e, logic [4:0] r);
        return e.v && e.rw && (e.d == r) && (r != 5'd0);
    endfunction

    // Distance 1 = just ahead (EX), distance 2 = two ahead (MEM).
    function automatic logic [1:0] fonte(logic [4:0] r);
        if (produz(hist[0], r) && !hist[0].mr) return 2'b10;
        if (produz(hist[1], r))                return 2'b01;
        return 2'b00;
    endfunction

    // Drives one cycle, checks it against the model, advances the model.
    task automatic run_cycle(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input bit urs, input bit urt,
                             input bit rdst, input bit rw, input bit mr,
                             input bit desv, input bit pronta);
        int   act;          // 0 normal, 1 stall, 2 flush, 3 freeze
        bit   lu;
        logic [3:0] exp_en, got_en;
        logic [1:0] nP, nS;
        ent_t novo, vazio;
        @(negedge clock);
        reset = rst; id_rs = rs; id_rt = rt; id_rd = rd;
        id_usa_rs = urs; id_usa_rt = urt; id_regDest = rdst;
        id_regwrite = rw; id_memread = mr; desvio_tomado = desv; mem_pronta = pronta;
        #1;
        lu  = hist[0].mr && ((urs && produz(hist[0], rs)) || (urt && produz(hist[0], rt)));
        act = !pronta ? 3 : desv ? 2 : lu ? 1 : 0;
        // {pc_escreve, ifid_escreve, ifid_limpa, idex_bolha}
        if (rst)           exp_en = 4'b0000;
        else if (act == 0) exp_en = 4'b1100;
        else if (act == 1) exp_en = 4'b0001;
        else if (act == 2) exp_en = 4'b1111;
        else               exp_en = 4'b0000;
        got_en = {pc_escreve, ifid_escreve, ifid_limpa, idex_bolha};
        total++;
        if (got_en !== exp_en) begin
            bad++;
            $display("FAIL enables t=%0t got=%b want=%b", $time, got_en, exp_en);
        end
        if (model_ok) begin
            total++;
            if ({controle1P, controle2P, controle1S, controle2S} !== {m_selP, m_selS}) begin
                bad++;
                $display("FAIL selects t=%0t got=%b want=%b", $time,
                         {controle1P, controle2P, controle1S, controle2S}, {m_selP, m_selS});
            end
            total++;
            if (contador_bolhas !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL counter t=%0t got=%0d want=%0d", $time, contador_bolhas, m_cnt);
            end
        end
        nP = fonte(rs);
        nS = fonte(rt);
        novo.v = 1; novo.rw = rw; novo.mr = mr; novo.d = rdst ? rd : rt;
        vazio.v = 0; vazio.rw = 0; vazio.mr = 0; vazio.d = 5'd0;
        @(posedge clock);
        if (rst) begin
            hist = '{vazio, vazio, vazio};
            m_selP = 2'b00; m_selS = 2'b00; m_cnt = 0; model_ok = 1;
        end else if (act == 0) begin
            hist.push_front(novo); void'(hist.pop_back());
            m_selP = nP; m_selS = nS;
        end else if (act != 3) begin
            hist.push_front(vazio); void'(hist.pop_back());
            m_selP = 2'b00; m_selS = 2'b00;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit urs, input bit urt, input bit rdst, input bit rw, input bit mr);
        run_cycle(0, rs, rt, rd, urs, urt, rdst, rw, mr, 0, 1);
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        run_cycle(1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1, 1, 0, 0);
        do_reset();
        #1;
        total++;
        if ({controle1P, controle2P, controle1S, controle2S, contador_bolhas} !== 20'd0) begin
            bad++;
            $display("FAIL reset_state got=%b/%0d want=0000/0",
                     {controle1P, controle2P, controle1S, controle2S}, contador_bolhas);
        end
    endtask

    task automatic test_fwd_exmem();
        do_reset();
        instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0);     // add r3
        instr(5'd3, 5'd6, 5'd7, 1, 1, 1, 1, 0);     // add r7 <- r3, r6
        #1;
        total++;
        if ({controle1P, controle2P} !== 2'b10) begin
            bad++;
            $display("FAIL fwd_exmem got=%b want=10", {controle1P, controle2P});
        end
        nop();
    endtask

    task automatic test_fwd_memwb();
        do_reset();
        instr(5'd1, 5'd5, 5'd0, 1, 0, 0, 1, 0);     // writes r5 via rt
        instr(5'd8, 5'd9, 5'd10, 1, 1, 1, 1, 0);    // unrelated
        instr(5'd11, 5'd5, 5'd12, 1, 1, 1, 1, 0);   // reads rt=5
        #1;
        total++;
        if ({controle1S, controle2S} !== 2'b01) begin
            bad++;
            $display("FAIL fwd_memwb got=%b want=01", {controle1S, controle2S});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instr(5'd1, 5'd4, 5'd0, 1, 0, 0, 1, 1);     // lw r4
        instr(5'd4, 5'd2, 5'd6, 1, 1, 1, 1, 0);     // consumer: stall cycle
        instr(5'd4, 5'd2, 5'd6, 1, 1, 1, 1, 0);     // consumer again: proceeds
        #1;
        total++;
        if ({controle1P, controle2P, contador_bolhas} !== {2'b01, 16'd1}) begin
            bad++;
            $display("FAIL load_use got=%b/%0d want=01/1", {controle1P, controle2P}, contador_bolhas);
        end
    endtask

    task automatic test_zero();
        do_reset();
        instr(5'd1, 5'd2, 5'd0, 1, 1, 1, 1, 0);     // writes r0
        instr(5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 1);     // load into r0
        instr(5'd0, 5'd0, 5'd3, 1, 1, 1, 1, 0);     // reads r0 twice, no stall
        #1;
        total++;
        if ({controle1P, controle2P, controle1S, controle2S, contador_bolhas} !== 20'd0) begin
            bad++;
            $display("FAIL reg_zero got=%b/%0d want=0000/0",
                     {controle1P, controle2P, controle1S, controle2S}, contador_bolhas);
        end
    endtask

    task automatic test_priority_flush();
        do_reset();
        instr(5'd1, 5'd4, 5'd0, 1, 0, 0, 1, 1);                 // lw r4
        run_cycle(0, 5'd4, 5'd4, 5'd6, 1, 1, 1, 1, 0, 1, 1);    // load-use + taken branch
        #1;
        total++;
        if (contador_bolhas !== 16'd1) begin
            bad++;
            $display("FAIL flush_count got=%0d want=1", contador_bolhas);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0);     // add r3
        instr(5'd3, 5'd0, 5'd0, 1, 0, 1, 0, 0);     // reads r3, writes nothing
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 5'd3, 5'd3, 5'd9, 1, 1, 1, 1, 0, 0, 0);
            #1;
            total++;
            if ({controle1P, controle2P} !== 2'b10) begin
                bad++;
                $display("FAIL freeze_hold cyc=%0d got=%b want=10", i, {controle1P, controle2P});
            end
        end
        instr(5'd3, 5'd3, 5'd9, 1, 1, 1, 1, 0);     // resumes: r3 now in MEM
        #1;
        total++;
        if ({controle1P, controle2P, controle1S, controle2S} !== 4'b0101) begin
            bad++;
            $display("FAIL freeze_resume got=%b want=0101",
                     {controle1P, controle2P, controle1S, controle2S});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);                 // flush: counter 1
        instr(5'd1, 5'd4, 5'd0, 1, 0, 0, 1, 1);                     // lw r4
        run_cycle(1, 5'd4, 5'd4, 5'd6, 1, 1, 1, 1, 0, 0, 1);        // reset over load-use
        #1;
        total++;
        if ({controle1P, controle2P, controle1S, controle2S, contador_bolhas} !== 20'd0) begin
            bad++;
            $display("FAIL reset_mid_stall got=%b/%0d want=0000/0",
                     {controle1P, controle2P, controle1S, controle2S}, contador_bolhas);
        end
        instr(5'd4, 5'd4, 5'd6, 1, 1, 1, 1, 0);                     // no stall now
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 99) < 2,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 99) < 35,
                      $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 85);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        end
        #1;
        total++;
        if (contador_bolhas !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturation got=%h want=ffff", contador_bolhas);
        end
    endtask

    initial begin
        ent_t vazio;
        vazio.v = 0; vazio.rw = 0; vazio.mr = 0; vazio.d = 5'd0;
        hist = '{vazio, vazio, vazio};
        m_selP = 2'b00; m_selS = 2'b00; m_cnt = 0;
        reset = 1; id_rs = 0; id_rt = 0; id_rd = 0;
        id_usa_rs = 0; id_usa_rt = 0; id_regDest = 0; id_regwrite = 0; id_memread = 0;
        desvio_tomado = 0; mem_pronta = 1;
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_load_use();
        test_zero();
        test_priority_flush();
        test_freeze();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_hazard.md
Name: controle_hazard

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Drives the four select lines of the EX-stage operand forwarding muxes: rs path and rt path, each a 3:1 mux over register file / Memoria (EX/MEM) / registrado (MEM/WB).
- Issues PC / IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Keeps an internal scoreboard of the instructions in EX, MEM and WB so that forwarding selects are registered and aligned with the instruction entering EX.

Parameters:
- REG_BITS, 5, width of register specifiers.
- LARGURA_CONT, 16, width of the saturating bubble counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs  input  REG_BITS  rs of the instruction in ID.
- id_rt  input  REG_BITS  rt of the instruction in ID.
- id_rd  input  REG_BITS  rd of the instruction in ID.
- id_usa_rs  input  1  instruction in ID reads rs.
- id_usa_rt  input  1  instruction in ID reads rt.
- id_regDest  input  1  destination select: 0 = rt, 1 = rd.
- id_regwrite  input  1  instruction in ID writes a register.
- id_memread  input  1  instruction in ID is a load.
- desvio_tomado  input  1  branch/jump resolved taken in EX this cycle.
- mem_pronta  input  1  data memory ready; 0 freezes the pipeline.
- pc_escreve  output  1  PC write enable.
- ifid_escreve  output  1  IF/ID write enable.
- ifid_limpa  output  1  IF/ID flush.
- idex_bolha  output  1  load a NOP into ID/EX.
- controle1P  output  1  rs forwarding select, registered.
- controle2P  output  1  rs forwarding select, registered.
- controle1S  output  1  rt forwarding select, registered.
- controle2S  output  1  rt forwarding select, registered.
- contador_bolhas  output  LARGURA_CONT  saturating count of inserted bubbles.

Behaviour:
- Mux select encoding (controle1,controle2):
  - 00 = register-file data.
  - 1x = Memoria (EX/MEM result).
  - 01 = registrado (MEM/WB result).
- Scoreboard:
  - Three slots: EX, MEM, WB. Each holds {valido, regwrite, memread, dest}.
  - dest = id_regDest ? id_rd : id_rt, captured when the ID instruction advances.
  - Each non-frozen cycle: WB <= MEM, MEM <= EX, EX <= ID descriptor, or an invalid slot when a bubble is inserted.
- Dependency match: a slot matches operand r when valido & regwrite & dest == r & r != 0.
  - Register 0 is never forwarded and never stalls.
- Action priority each cycle, decided combinationally (highest first):
  - FREEZE: mem_pronta=0.
    - pc_escreve=0, ifid_escreve=0, idex_bolha=0, ifid_limpa=0.
    - Scoreboard, forwarding registers and counter hold.
  - FLUSH: desvio_tomado=1.
    - ifid_limpa=1, idex_bolha=1, pc_escreve=1, ifid_escreve=1.
    - EX slot <= invalid; counter +1.
  - STALL: EX slot matches a used operand (id_usa_rs/id_usa_rt) and EX.memread=1 (load-use).
    - pc_escreve=0, ifid_escreve=0, idex_bolha=1.
    - EX slot <= invalid; counter +1.
  - NORMAL: pc_escreve=1, ifid_escreve=1, all others 0.
- Forwarding registers:
  - Updated only in NORMAL; cleared to 00 on FLUSH or STALL (the bubble entering EX); held on FREEZE.
  - For each operand, computed from the current slots:
    - EX slot matches and is not a load → 10.
    - else MEM slot matches → 01.
    - else → 00.
  - Nearest producer wins: if EX and MEM both match, select 10.
  - Latency: selects are valid in the cycle the instruction occupies EX (one cycle after ID).
- After a one-cycle load stall, the load sits in MEM while the consumer is in ID, so the consumer receives 01 (registrado). No second stall.
- Counter saturates at all-ones; no wrap.
- Reset (synchronous; dominates all inputs, including mid-stall or mid-freeze):
  - All slots invalid; forwarding selects 00; counter 0.
  - While reset=1: pc_escreve=0, ifid_escreve=0, ifid_limpa=0, idex_bolha=0.
  - First cycle after reset is NORMAL.

Decomposition:
- Shared package pkg_pipeline holds:
  - Forwarding select constants SEL_REG=2'b00, SEL_MEM=2'b10, SEL_WB=2'b01.
  - Scoreboard slot typedef {valido, regwrite, memread, dest}.
  - Action enum {NORMAL, STALL, FLUSH, FREEZE}.
- One natural sub-module: unidade_adiantamento, a pure combinational comparator computing the 2-bit select for one operand. Instantiated twice (rs, rt).

Test Plan:
- Forwarding from EX/MEM: add r3 in ID, then add with rs=3 → {controle1P,controle2P}=10 in the consumer's EX cycle; no stall.
- Forwarding from MEM/WB: write r5, then one unrelated instruction, then a consumer with rt=5 → {controle1S,controle2S}=01.
- Load-use: lw r4, then a consumer with rs=4 → one cycle with pc_escreve=0 and idex_bolha=1, contador_bolhas=1; the consumer's EX select is 01.
- Register zero: producer writes r0, consumer reads r0 → selects 00, no stall.
- Priority cases:
  - desvio_tomado coincides with a load-use condition → FLUSH (ifid_limpa=1, pc_escreve=1); counter +1, not +2.
  - mem_pronta=0 for 3 cycles during a dependent sequence → all enables 0 and selects held; resumes identically afterwards.
- Reset asserted mid-stall → next cycle all selects 00, counter 0, NORMAL behaviour after deassertion; counter saturation at 16'hFFFF checked by forcing repeated flushes.
